serializer_multi: RTL and testbench

Parametrised, single-clock, multi-channel parallel-to-serial converter in portable RTL, generalising the vendor output serializer primitive. It accepts one word per channel through a valid/ready handshake, buffers one word, and emits `BITS_PER_CLK` bits per channel per cycle, LSB first. Use 1 for SDR pins and 2 to feed a DDR output register. It sits between TMDS/LVDS encoders and the IO-register layer, and it simulates and lints without vendor models.

---
 rtl/serializer_multi.sv | 148 ++++++++++++++
 tb/tb_serializer_multi.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serializer_multi.sv
// serializer_multi: multi-lane parallel-to-serial converter with a one-word
// holding buffer and valid/ready intake, emitting BITS_PER_CLK bits per lane
// per cycle, LSB first.
// Optional feature macro: SERIALIZER_TRISTATE_EN adds the per-lane output
// enable input (in_oe) and its registered, slot-aligned copy (ser_oe).
module serializer_multi #(
    parameter int unsigned CHANNELS     = 3,
    parameter int unsigned DATA_WIDTH   = 10,
    parameter int unsigned BITS_PER_CLK = 1,
    parameter bit          IDLE_BIT     = 1'b0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [CHANNELS*DATA_WIDTH-1:0]   in_data,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic [CHANNELS*BITS_PER_CLK-1:0] ser_out,
    output logic                             word_start,
    output logic                             underflow
`ifdef SERIALIZER_TRISTATE_EN
    ,
    input  logic [CHANNELS-1:0]              in_oe,
    output logic [CHANNELS-1:0]              ser_oe
`endif
);

    localparam int unsigned SLOTS  = DATA_WIDTH / BITS_PER_CLK;
    localparam int unsigned SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int unsigned WORD_W = CHANNELS * DATA_WIDTH;
    localparam int unsigned SER_W  = CHANNELS * BITS_PER_CLK;

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SLOTS - 1);
    localparam logic [SER_W-1:0]  IDLE_OUT  = {SER_W{IDLE_BIT}};

    // Reject geometries that cannot be sliced evenly into at least two slots
    if ((BITS_PER_CLK != 1 && BITS_PER_CLK != 2) ||
        ((DATA_WIDTH % BITS_PER_CLK) != 0) || (SLOTS < 2)) begin : g_cfg_error
        $error("serializer_multi: DATA_WIDTH must split into >= 2 slots of 1 or 2 bits");
    end

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t              state;
    logic [WORD_W-1:0]   hold;
    logic                hold_valid;
    logic [WORD_W-1:0]   shift;
    logic [SLOT_W-1:0]   slot;

`ifdef SERIALIZER_TRISTATE_EN
    logic [CHANNELS-1:0] hold_oe;
`endif

    logic accept;
    logic last_slot;
    logic load;

    // Select slot s of every lane; constant-index loop keeps the mux static
    function automatic logic [SER_W-1:0] slice_of(
        input logic [WORD_W-1:0] w,
        input logic [SLOT_W-1:0] s
    );
        logic [SER_W-1:0] r;
        r = '0;
        for (int unsigned k = 0; k < SLOTS; k++) begin
            if (s == SLOT_W'(k)) begin
                for (int unsigned c = 0; c < CHANNELS; c++) begin
                    r[c*BITS_PER_CLK +: BITS_PER_CLK] =
                        w[c*DATA_WIDTH + k*BITS_PER_CLK +: BITS_PER_CLK];
                end
            end
        end
        return r;
    endfunction

    // Holding register is free whenever it is empty and reset is released
    assign in_ready = !hold_valid && !rst;

    // Handshake and load decode
    always_comb begin
        accept    = in_valid && in_ready;
        last_slot = (state == RUN) && (slot == LAST_SLOT);
        load      = hold_valid && ((state == IDLE) || last_slot);
    end

    // Holding register: filled on accept, emptied when the shifter takes it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold       <= '0;
            hold_valid <= 1'b0;
`ifdef SERIALIZER_TRISTATE_EN
            hold_oe    <= '0;
`endif
        end else if (accept) begin
            hold       <= in_data;
            hold_valid <= 1'b1;
`ifdef SERIALIZER_TRISTATE_EN
            hold_oe    <= in_oe;
`endif
        end else if (load) begin
            hold_valid <= 1'b0;
        end
    end

    // Shift FSM: load / advance slot / drop to idle, all outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            shift      <= '0;
            slot       <= '0;
            ser_out    <= IDLE_OUT;
            word_start <= 1'b0;
            underflow  <= 1'b0;
`ifdef SERIALIZER_TRISTATE_EN
            ser_oe     <= '0;
`endif
        end else begin
            word_start <= 1'b0;
            underflow  <= 1'b0;
            if (load) begin
                // New word: slot 0 goes out on the very next cycle, no gap
                state      <= RUN;
                shift      <= hold;
                slot       <= '0;
                ser_out    <= slice_of(hold, '0);
                word_start <= 1'b1;
`ifdef SERIALIZER_TRISTATE_EN
                ser_oe     <= hold_oe;
`endif
            end else if ((state == RUN) && !last_slot) begin
                slot    <= slot + SLOT_W'(1);
                ser_out <= slice_of(shift, slot + SLOT_W'(1));
            end else begin
                // Idle, or the word just ended with nothing buffered behind it
                underflow <= (state == RUN);
                state     <= IDLE;
                slot      <= '0;
                ser_out   <= IDLE_OUT;
`ifdef SERIALIZER_TRISTATE_EN
                ser_oe    <= '0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_serializer_multi.sv
// Bench for serializer_multi: a transaction-level model checks the default
// instance every cycle; a second instance with BITS_PER_CLK=2 gets directed
// checks. Tristate checks are active when SERIALIZER_TRISTATE_EN is defined.
module tb_serializer_multi;

    localparam int CH  = 3;
    localparam int DW  = 10;
    localparam int SL1 = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // default instance
    logic [CH*DW-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [CH-1:0]    ser_out;
    logic             word_start;
    logic             underflow;
    logic [CH-1:0]    in_oe;

    // BITS_PER_CLK = 2 instance
    logic [CH*DW-1:0] in2_data;
    logic             in2_valid;
    logic             in2_ready;
    logic [2*CH-1:0]  ser2;
    logic             ws2;
    logic             uf2;
    logic [CH-1:0]    in2_oe;

`ifdef SERIALIZER_TRISTATE_EN
    logic [CH-1:0]    ser_oe;
    logic [CH-1:0]    ser2_oe;
`endif

    serializer_multi #(.CHANNELS(CH), .DATA_WIDTH(DW), .BITS_PER_CLK(1), .IDLE_BIT(1'b0)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .ser_out(ser_out), .word_start(word_start), .underflow(underflow)
`ifdef SERIALIZER_TRISTATE_EN
        , .in_oe(in_oe), .ser_oe(ser_oe)
`endif
    );

    serializer_multi #(.CHANNELS(CH), .DATA_WIDTH(DW), .BITS_PER_CLK(2), .IDLE_BIT(1'b0)) dut2 (
        .clk(clk), .rst(rst), .in_data(in2_data), .in_valid(in2_valid), .in_ready(in2_ready),
        .ser_out(ser2), .word_start(ws2), .underflow(uf2)
`ifdef SERIALIZER_TRISTATE_EN
        , .in_oe(in2_oe), .ser_oe(ser2_oe)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model of the default instance ----------------
    logic [CH*DW-1:0] m_pend   = '0;
    logic [CH*DW-1:0] m_cur    = '0;
    logic [CH-1:0]    m_pend_oe = '0;
    logic [CH-1:0]    m_cur_oe  = '0;
    bit               m_pend_v = 1'b0;
    int               m_pos    = -1;   // slot currently on the pins, -1 = idle
    bit               m_ws     = 1'b0;
    bit               m_uf     = 1'b0;

    task automatic model_step();
        bit acc;
        acc  = in_valid && !m_pend_v;
        m_ws = 1'b0;
        m_uf = 1'b0;
        if (m_pos >= 0 && m_pos < SL1 - 1) begin
            m_pos++;
        end else if (m_pend_v) begin
            m_cur    = m_pend;
            m_cur_oe = m_pend_oe;
            m_pend_v = 1'b0;
            m_pos    = 0;
            m_ws     = 1'b1;
        end else if (m_pos == SL1 - 1) begin
            m_pos = -1;
            m_uf  = 1'b1;
        end
        if (acc) begin
            m_pend    = in_data;
            m_pend_oe = in_oe;
            m_pend_v  = 1'b1;
        end
    endtask

    function automatic logic [CH-1:0] exp_ser();
        logic [CH-1:0] r;
        r = '0;
        for (int c = 0; c < CH; c++)
            r[c] = (m_pos < 0) ? 1'b0 : m_cur[c*DW + m_pos];
        return r;
    endfunction

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_pend_v = 1'b0;
                m_pos    = -1;
                m_ws     = 1'b0;
                m_uf     = 1'b0;
            end else begin
                model_step();
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    bit chk_en = 1'b0;
    bit rec_en = 1'b0;
    int cyc    = 0;
    int ws_cnt = 0;
    int uf_cnt = 0;
    int ws_q[$];

    initial begin
        wait (chk_en);
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            check("m_ser_out", 64'(ser_out), 64'(exp_ser()));
            check("m_word_start", 64'(word_start), 64'(m_ws));
            check("m_underflow", 64'(underflow), 64'(m_uf));
            check("m_in_ready", 64'(in_ready), 64'(!m_pend_v && !rst));
`ifdef SERIALIZER_TRISTATE_EN
            check("m_ser_oe", 64'(ser_oe), 64'((m_pos < 0) ? 3'b000 : m_cur_oe));
`endif
            if (rec_en) begin
                if (word_start) begin
                    ws_cnt++;
                    ws_q.push_back(cyc);
                end
                if (underflow) uf_cnt++;
            end
        end
    end

    // Offer a word on the default instance; called at a falling edge, returns
    // at the falling edge after the accepting rising edge.
    task automatic send(input logic [CH*DW-1:0] w, input logic [CH-1:0] oe);
        int n;
        n        = 0;
        in_data  = w;
        in_oe    = oe;
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout: in_ready got 0 expected 1 at t=%0t", $time);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    int bits1[10] = '{1, 0, 1, 0, 0, 1, 0, 1, 0, 1};   // 0x2A5, LSB first

    initial begin
        in_data   = '0;
        in_valid  = 1'b0;
        in_oe     = '0;
        in2_data  = '0;
        in2_valid = 1'b0;
        in2_oe    = '0;
        rst       = 1'b1;
        repeat (3) @(negedge clk);

        // reset state
        check("rst_ser_out", 64'(ser_out), 64'(3'b000));
        check("rst_in_ready", 64'(in_ready), 64'(0));
        check("rst_word_start", 64'(word_start), 64'(0));
        check("rst_underflow", 64'(underflow), 64'(0));
        rst = 1'b0;
        #1;
        check("rel_in_ready", 64'(in_ready), 64'(1));
        chk_en = 1'b1;
        @(negedge clk);

        // 1: single word 0x2A5 on all lanes (OE 101 when tristate present)
        send({3{10'h2A5}}, 3'b101);
        for (int k = 1; k <= 11; k++) begin
            @(posedge clk);
            #1;
            if (k <= 10) begin
                check("t1_ser_out", 64'(ser_out), 64'((bits1[k-1] != 0) ? 3'b111 : 3'b000));
                check("t1_word_start", 64'(word_start), 64'(k == 1));
                check("t1_underflow", 64'(underflow), 64'(0));
            end else begin
                check("t1_idle_ser_out", 64'(ser_out), 64'(3'b000));
                check("t1_underflow_end", 64'(underflow), 64'(1));
            end
`ifdef SERIALIZER_TRISTATE_EN
            check("t6_ser_oe", 64'(ser_oe), 64'((k <= 10) ? 3'b101 : 3'b000));
`endif
        end
        @(negedge clk);

        // 5: lane mapping, lane c carries 1 << c
        send({10'h004, 10'h002, 10'h001}, 3'b000);
        for (int s = 0; s < 4; s++) begin
            @(posedge clk);
            #1;
            check("t5_lane_map", 64'(ser_out), 64'((s < 3) ? 3'(1 << s) : 3'b000));
        end
        repeat (10) @(negedge clk);

        // 3: 16 back-to-back incrementing words
        ws_cnt = 0;
        uf_cnt = 0;
        ws_q.delete();
        rec_en = 1'b1;
        for (int i = 0; i < 16; i++)
            send({10'(i*3 + 2), 10'(i*3 + 1), 10'(i*3)}, 3'(i));
        repeat (25) @(negedge clk);
        rec_en = 1'b0;
        check("t3_word_count", 64'(ws_cnt), 64'(16));
        check("t3_underflow_count", 64'(uf_cnt), 64'(1));
        for (int i = 1; i < ws_q.size(); i++)
            check("t3_word_period", 64'(ws_q[i] - ws_q[i-1]), 64'(10));

        // 4: reset at slot 4 while a second word is held
        send({3{10'h3FF}}, 3'b111);
        send({3{10'h155}}, 3'b011);
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("t4_async_ser_out", 64'(ser_out), 64'(3'b000));
        check("t4_async_in_ready", 64'(in_ready), 64'(0));
        check("t4_async_word_start", 64'(word_start), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            check("t4_post_ser_out", 64'(ser_out), 64'(3'b000));
            check("t4_post_word_start", 64'(word_start), 64'(0));
        end
        @(negedge clk);

        // 2: BITS_PER_CLK=2, 0x3FF then 0x000 back to back
        in2_data  = {3{10'h3FF}};
        in2_valid = 1'b1;
        check("t2_ready_idle", 64'(in2_ready), 64'(1));
        @(posedge clk);
        #1;
        check("t2_ready_after_accept", 64'(in2_ready), 64'(0));
        @(negedge clk);
        in2_data = '0;
        for (int k = 1; k <= 11; k++) begin
            @(posedge clk);
            #1;
            check("t2_ser_out", 64'(ser2), 64'((k <= 5) ? 6'h3F : 6'h00));
            check("t2_word_start", 64'(ws2), 64'(k == 1 || k == 6));
            check("t2_underflow", 64'(uf2), 64'(k == 11));
            check("t2_in_ready", 64'(in2_ready), 64'(k == 1 || k >= 6));
            if (k == 2) in2_valid = 1'b0;
        end
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
